// File: rtl/pe_sched_pkg.sv
// Shared types and constants for the bit-column PE scheduler.
// Latency: n/a (package). Backpressure: n/a.
// Optional perf counters are enabled by defining PE_SCHED_PERF_EN.
package pe_sched_pkg;

  localparam int NUM_LANES_DEF = 4;
  localparam int SHIFT_W_DEF   = 3;
  localparam int PERF_W        = 16;

  localparam logic [1:0] ACC_EN_8   = 2'd0;
  localparam logic [1:0] ACC_EN_16  = 2'd1;
  localparam logic [1:0] ACC_EN_32  = 2'd2;
  localparam logic [1:0] ACC_EN_RSV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + {{(PERF_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pe_sched_perf.sv
// Three saturating 16-bit activity counters for the PE scheduler.
// Latency: count visible the cycle after the event. Backpressure: none.
// Only instantiated when PE_SCHED_PERF_EN is defined.
module pe_sched_perf
  import pe_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              inc_busy,
  input  logic              inc_stall,
  input  logic              inc_issue,
  output logic [PERF_W-1:0] perf_busy,
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_issue
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_busy  <= '0;
      perf_stall <= '0;
      perf_issue <= '0;
    end else if (clr) begin
      perf_busy  <= '0;
      perf_stall <= '0;
      perf_issue <= '0;
    end else begin
      if (inc_busy)  perf_busy  <= sat_inc(perf_busy);
      if (inc_stall) perf_stall <= sat_inc(perf_stall);
      if (inc_issue) perf_issue <= sat_inc(perf_issue);
    end
  end

endmodule

// File: rtl/pe_bitcol_sched.sv
// Per-PE scheduler: pops lockstep bit-column streams and drives the bit-serial PE.
// Latency: col_idx -> pe_shift_offset combinational; any lane not ready stalls all lanes.
// Response held until rsp_ready. PE_SCHED_PERF_EN adds perf_busy/perf_stall/perf_issue.
module pe_bitcol_sched
  import pe_sched_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int SHIFT_W   = SHIFT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_acc_en,
  input  logic                         cmd_sign_en,
  input  logic [NUM_LANES-1:0]         cmd_lane_empty,
  input  logic [NUM_LANES-1:0]         col_valid,
  input  logic [NUM_LANES*SHIFT_W-1:0] col_idx,
  input  logic [NUM_LANES-1:0]         col_last,
  output logic [NUM_LANES-1:0]         col_ready,
  output logic [NUM_LANES*SHIFT_W-1:0] pe_shift_offset,
  output logic                         pe_weight_valid,
  output logic                         pe_act_valid,
  output logic                         pe_sign_en,
  output logic [1:0]                   pe_acc_en,
  output logic [NUM_LANES-1:0]         pe_zcip_done,
  input  logic                         pe_done,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
`ifdef PE_SCHED_PERF_EN
  output logic [PERF_W-1:0]            perf_busy,
  output logic [PERF_W-1:0]            perf_stall,
  output logic [PERF_W-1:0]            perf_issue,
`endif
  output logic                         busy
);

  state_t                       state;
  logic [NUM_LANES-1:0]         fin;
  logic [1:0]                   acc_q;
  logic                         sign_q;
  logic [NUM_LANES*SHIFT_W-1:0] shift_hold;
  logic [NUM_LANES*SHIFT_W-1:0] shift_issue;
  logic [NUM_LANES-1:0]         fin_nxt;
  logic                         in_run;
  logic                         issue;

  assign in_run = (state == ST_RUN);
  // Finished lanes count as ready so the remaining lanes keep stepping together.
  assign issue  = in_run && (&(col_valid | fin));

  always_comb begin
    shift_issue = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      shift_issue[i*SHIFT_W +: SHIFT_W] = fin[i] ? '0 : col_idx[i*SHIFT_W +: SHIFT_W];
    end
  end

  // On issue every non-fin lane is popped, so its col_last marks it finished.
  assign fin_nxt = fin | (col_last & ~fin);

  assign cmd_ready       = (state == ST_IDLE);
  assign busy            = (state != ST_IDLE);
  assign col_ready       = issue ? ~fin : '0;
  assign pe_shift_offset = issue ? shift_issue : shift_hold;
  assign pe_weight_valid = issue || (state == ST_DRAIN);
  assign pe_act_valid    = in_run || (state == ST_DRAIN);
  assign pe_zcip_done    = fin;
  assign pe_sign_en      = busy & sign_q;
  assign pe_acc_en       = busy ? acc_q : 2'b00;
  assign rsp_valid       = (state == ST_RESP);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      fin        <= '0;
      acc_q      <= ACC_EN_8;
      sign_q     <= 1'b0;
      shift_hold <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            acc_q  <= cmd_acc_en;
            sign_q <= cmd_sign_en;
            fin    <= cmd_lane_empty;
            state  <= (&cmd_lane_empty) ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue) begin
            fin        <= fin_nxt;
            shift_hold <= shift_issue;
            if (&fin_nxt) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pe_done) state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
            fin   <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PE_SCHED_PERF_EN
  pe_sched_perf u_perf (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (cmd_valid & cmd_ready),
    .inc_busy   (busy),
    .inc_stall  (in_run & ~issue),
    .inc_issue  (issue),
    .perf_busy  (perf_busy),
    .perf_stall (perf_stall),
    .perf_issue (perf_issue)
  );
`endif

endmodule

// File: tb/tb_pe_bitcol_sched.sv
// Directed per-cycle vector bench for pe_bitcol_sched.
module tb_pe_bitcol_sched;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, cmd_valid, cmd_ready, cmd_sign_en;
  logic [1:0]  cmd_acc_en, pe_acc_en;
  logic [3:0]  cmd_lane_empty, col_valid, col_last, col_ready, pe_zcip_done;
  logic [11:0] col_idx, pe_shift_offset;
  logic        pe_weight_valid, pe_act_valid, pe_sign_en, pe_done;
  logic        rsp_valid, rsp_ready, busy;
`ifdef PE_SCHED_PERF_EN
  logic [15:0] perf_busy, perf_stall, perf_issue;
`endif

  pe_bitcol_sched dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_acc_en(cmd_acc_en), .cmd_sign_en(cmd_sign_en),
    .cmd_lane_empty(cmd_lane_empty),
    .col_valid(col_valid), .col_idx(col_idx), .col_last(col_last), .col_ready(col_ready),
    .pe_shift_offset(pe_shift_offset), .pe_weight_valid(pe_weight_valid),
    .pe_act_valid(pe_act_valid), .pe_sign_en(pe_sign_en), .pe_acc_en(pe_acc_en),
    .pe_zcip_done(pe_zcip_done), .pe_done(pe_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
`ifdef PE_SCHED_PERF_EN
    .perf_busy(perf_busy), .perf_stall(perf_stall), .perf_issue(perf_issue),
`endif
    .busy(busy)
  );

  typedef struct {
    string       name;
    logic        rstn, cmd_v;
    logic [3:0]  empty, cv;
    logic [11:0] ci;
    logic [3:0]  cl;
    logic        done, rr;
    logic        e_cr;
    logic [3:0]  e_colr;
    logic [11:0] e_sh;
    logic        e_wv, e_av;
    logic [3:0]  e_zd;
    logic        e_rv, e_busy;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t mk(string name, logic r, logic cv_cmd, logic [3:0] empty,
                              logic [3:0] cv, logic [11:0] ci, logic [3:0] cl,
                              logic done, logic rr, logic e_cr, logic [3:0] e_colr,
                              logic [11:0] e_sh, logic e_wv, logic e_av, logic [3:0] e_zd,
                              logic e_rv, logic e_busy);
    vec_t v;
    v.name = name; v.rstn = r; v.cmd_v = cv_cmd; v.empty = empty;
    v.cv = cv; v.ci = ci; v.cl = cl; v.done = done; v.rr = rr;
    v.e_cr = e_cr; v.e_colr = e_colr; v.e_sh = e_sh; v.e_wv = e_wv; v.e_av = e_av;
    v.e_zd = e_zd; v.e_rv = e_rv; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rstn = v.rstn; cmd_valid = v.cmd_v; cmd_lane_empty = v.empty;
    col_valid = v.cv; col_idx = v.ci; col_last = v.cl;
    pe_done = v.done; rsp_ready = v.rr;
    cmd_acc_en = 2'b10; cmd_sign_en = 1'b1;
  endtask

  task automatic check(input vec_t v);
    logic [27:0] act, exp;
    act = {cmd_ready, col_ready, pe_shift_offset, pe_weight_valid, pe_act_valid,
           pe_zcip_done, rsp_valid, busy, pe_sign_en, pe_acc_en};
    exp = {v.e_cr, v.e_colr, v.e_sh, v.e_wv, v.e_av, v.e_zd, v.e_rv, v.e_busy,
           v.e_busy, v.e_busy ? 2'b10 : 2'b00};
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", v.name, act, exp);
  endtask

  task automatic run(input vec_t v);
    apply(v);
    #4;
    check(v);
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  initial begin
    //          name         rst cmd empty  cv    ci        cl   dn rr  cr colr  sh       wv av zd     rv bsy
    tbl.push_back(mk("rst0",   0, 0, 4'h0, 4'h0, 12'o0000, 4'h0, 0, 0, 1, 4'h0, 12'o0000, 0, 0, 4'h0, 0, 0));
    tbl.push_back(mk("rst1",   0, 0, 4'h0, 4'h0, 12'o0000, 4'h0, 0, 0, 1, 4'h0, 12'o0000, 0, 0, 4'h0, 0, 0));
    tbl.push_back(mk("rst2",   0, 0, 4'h0, 4'h0, 12'o0000, 4'h0, 0, 0, 1, 4'h0, 12'o0000, 0, 0, 4'h0, 0, 0));
    tbl.push_back(mk("idle",   1, 0, 4'h0, 4'h0, 12'o0000, 4'h0, 1, 0, 1, 4'h0, 12'o0000, 0, 0, 4'h0, 0, 0));
    tbl.push_back(mk("t2cmd",  1, 1, 4'h0, 4'h0, 12'o0000, 4'h0, 0, 0, 1, 4'h0, 12'o0000, 0, 0, 4'h0, 0, 0));
    tbl.push_back(mk("t2col0", 1, 0, 4'h0, 4'hF, 12'o3333, 4'h0, 1, 0, 0, 4'hF, 12'o3333, 1, 1, 4'h0, 0, 1));
    tbl.push_back(mk("t2col1", 1, 0, 4'h0, 4'hF, 12'o1111, 4'hF, 0, 0, 0, 4'hF, 12'o1111, 1, 1, 4'h0, 0, 1));
    tbl.push_back(mk("t2drn",  1, 0, 4'h0, 4'h0, 12'o0000, 4'h0, 0, 0, 0, 4'h0, 12'o1111, 1, 1, 4'hF, 0, 1));
    tbl.push_back(mk("t2done", 1, 0, 4'h0, 4'h0, 12'o0000, 4'h0, 1, 0, 0, 4'h0, 12'o1111, 1, 1, 4'hF, 0, 1));
    tbl.push_back(mk("t2resp", 1, 0, 4'h0, 4'h0, 12'o0000, 4'h0, 0, 0, 0, 4'h0, 12'o1111, 0, 0, 4'hF, 1, 1));
    tbl.push_back(mk("t2ovl",  1, 1, 4'h0, 4'h0, 12'o0000, 4'h0, 0, 1, 0, 4'h0, 12'o1111, 0, 0, 4'hF, 1, 1));
    tbl.push_back(mk("t2idle", 1, 0, 4'h0, 4'h0, 12'o0000, 4'h0, 0, 0, 1, 4'h0, 12'o1111, 0, 0, 4'h0, 0, 0));
    tbl.push_back(mk("t3cmd",  1, 1, 4'h4, 4'h0, 12'o0000, 4'h0, 0, 0, 1, 4'h0, 12'o1111, 0, 0, 4'h0, 0, 0));
    tbl.push_back(mk("t3col",  1, 0, 4'h0, 4'hF, 12'o2765, 4'hF, 0, 0, 0, 4'hB, 12'o2065, 1, 1, 4'h4, 0, 1));
    tbl.push_back(mk("t3drn",  1, 0, 4'h0, 4'hF, 12'o0000, 4'h0, 1, 0, 0, 4'h0, 12'o2065, 1, 1, 4'hF, 0, 1));
    tbl.push_back(mk("t3resp", 1, 0, 4'h0, 4'h0, 12'o0000, 4'h0, 0, 1, 0, 4'h0, 12'o2065, 0, 0, 4'hF, 1, 1));
    tbl.push_back(mk("t5cmd",  1, 1, 4'hF, 4'h0, 12'o0000, 4'h0, 0, 0, 1, 4'h0, 12'o2065, 0, 0, 4'h0, 0, 0));
    tbl.push_back(mk("t5drn",  1, 0, 4'h0, 4'hF, 12'o7777, 4'hF, 0, 0, 0, 4'h0, 12'o2065, 1, 1, 4'hF, 0, 1));
    tbl.push_back(mk("t5done", 1, 0, 4'h0, 4'hF, 12'o7777, 4'hF, 1, 0, 0, 4'h0, 12'o2065, 1, 1, 4'hF, 0, 1));
    tbl.push_back(mk("t5resp", 1, 0, 4'h0, 4'h0, 12'o0000, 4'h0, 0, 1, 0, 4'h0, 12'o2065, 0, 0, 4'hF, 1, 1));
    tbl.push_back(mk("t5idle", 1, 0, 4'h0, 4'h0, 12'o0000, 4'h0, 1, 0, 1, 4'h0, 12'o2065, 0, 0, 4'h0, 0, 0));

    apply(tbl[0]);
    @(posedge clk);
    #1;
    foreach (tbl[i]) run(tbl[i]);

    // Lane 1 starves for 5 cycles: everything freezes, then lockstep resumes.
    run(mk("t4cmd",   1, 1, 4'h0, 4'h0, 12'o0000, 4'h0, 0, 0, 1, 4'h0, 12'o2065, 0, 0, 4'h0, 0, 0));
    run(mk("t4col0",  1, 0, 4'h0, 4'hF, 12'o4444, 4'h0, 0, 0, 0, 4'hF, 12'o4444, 1, 1, 4'h0, 0, 1));
    for (int s = 0; s < 5; s++)
      run(mk($sformatf("t4stall%0d", s),
             1, 0, 4'h0, 4'hD, 12'o7777, 4'h0, 0, 0, 0, 4'h0, 12'o4444, 0, 1, 4'h0, 0, 1));
    run(mk("t4col1",  1, 0, 4'h0, 4'hF, 12'o5555, 4'hF, 0, 0, 0, 4'hF, 12'o5555, 1, 1, 4'h0, 0, 1));
`ifdef PE_SCHED_PERF_EN
    check_val("perf_stall", perf_stall, 16'd5);
    check_val("perf_issue", perf_issue, 16'd2);
`endif
    run(mk("t4done",  1, 0, 4'h0, 4'h0, 12'o0000, 4'h0, 1, 0, 0, 4'h0, 12'o5555, 1, 1, 4'hF, 0, 1));
    run(mk("t4resp",  1, 0, 4'h0, 4'h0, 12'o0000, 4'h0, 0, 1, 0, 4'h0, 12'o5555, 0, 0, 4'hF, 1, 1));

    // Reset after three issues aborts the job; the next job runs clean.
    run(mk("t6cmd",   1, 1, 4'h0, 4'h0, 12'o0000, 4'h0, 0, 0, 1, 4'h0, 12'o5555, 0, 0, 4'h0, 0, 0));
    for (int s = 0; s < 3; s++)
      run(mk($sformatf("t6iss%0d", s),
             1, 0, 4'h0, 4'hF, 12'o1234, 4'h0, 0, 0, 0, 4'hF, 12'o1234, 1, 1, 4'h0, 0, 1));
    run(mk("t6rst",   0, 0, 4'h0, 4'hF, 12'o6666, 4'h0, 0, 0, 0, 4'hF, 12'o6666, 1, 1, 4'h0, 0, 1));
    run(mk("t6after", 1, 0, 4'h0, 4'h0, 12'o0000, 4'h0, 0, 0, 1, 4'h0, 12'o0000, 0, 0, 4'h0, 0, 0));
    run(mk("t6cmd2",  1, 1, 4'h8, 4'h0, 12'o0000, 4'h0, 0, 0, 1, 4'h0, 12'o0000, 0, 0, 4'h0, 0, 0));
    run(mk("t6col",   1, 0, 4'h0, 4'h7, 12'o0321, 4'h7, 0, 0, 0, 4'h7, 12'o0321, 1, 1, 4'h8, 0, 1));
    run(mk("t6done",  1, 0, 4'h0, 4'h0, 12'o0000, 4'h0, 1, 0, 0, 4'h0, 12'o0321, 1, 1, 4'hF, 0, 1));
    run(mk("t6resp",  1, 0, 4'h0, 4'h0, 12'o0000, 4'h0, 0, 1, 0, 4'h0, 12'o0321, 0, 0, 4'hF, 1, 1));
    run(mk("t6idle",  1, 0, 4'h0, 4'h0, 12'o0000, 4'h0, 0, 0, 1, 4'h0, 12'o0321, 0, 0, 4'h0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
